// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer. One shared 1-bit full adder (sum, propagate,
// generate) is fed one operand bit per cycle, LSB first. The carry is rebuilt each
// cycle as G | (P & Cin). After the last bit the raw sum is optionally saturated on
// signed overflow, and the result and Z/V/N flags are registered together.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter bit          SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  // Most positive and most negative two's-complement values
  localparam logic [WIDTH-1:0] SatPos = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SatNeg = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  // Sign of the captured A operand; opa_q is shifted away by the time it is needed
  logic             msb_a_q, msb_a_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_v_q, flag_v_d;
  logic             flag_n_q, flag_n_d;

  // ---------------------------------------------------------------------------
  // Shared 1-bit full adder
  // ---------------------------------------------------------------------------
  logic fa_a, fa_b, fa_cin;
  logic fa_s, fa_p, fa_g;

  // One-bit adder producing sum, propagate and generate
  always_comb begin
    fa_a   = opa_q[0];
    fa_b   = opb_q[0];
    fa_cin = carry_q;
    fa_p   = fa_a ^ fa_b;
    fa_g   = fa_a & fa_b;
    fa_s   = fa_p ^ fa_cin;
  end

  // ---------------------------------------------------------------------------
  // Datapath helpers for the current bit
  // ---------------------------------------------------------------------------
  logic             carry_nxt;
  logic             last_bit;
  logic             ovf;
  logic [WIDTH-1:0] sum_shift;
  logic [WIDTH-1:0] sat_value;
  logic [WIDTH-1:0] final_result;

  // Carry recovery, sum shift-in and end-of-op result selection
  always_comb begin
    carry_nxt = fa_g | (fa_p & carry_q);
    last_bit  = (state_q == StRun) && (cnt_q == LastBit);
    sum_shift = {fa_s, sum_q[WIDTH-1:1]};
    // Only meaningful on the MSB: carry into it versus carry out of it
    ovf       = carry_q ^ carry_nxt;
    sat_value = msb_a_q ? SatNeg : SatPos;
    if (ovf && SAT) begin
      final_result = sat_value;
    end else begin
      final_result = sum_shift;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // Sequencer: capture in IDLE, one bit per cycle in RUN, commit on the last bit
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    msb_a_d  = msb_a_q;
    result_d = result_q;
    flag_z_d = flag_z_q;
    flag_v_d = flag_v_q;
    flag_n_d = flag_n_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          msb_a_d = a[WIDTH-1];
          cnt_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        sum_d   = sum_shift;
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = carry_nxt;
        cnt_d   = cnt_q + 1'b1;
        if (last_bit) begin
          result_d = final_result;
          flag_z_d = (final_result == '0);
          flag_v_d = ovf;
          flag_n_d = final_result[WIDTH-1];
          cnt_d    = '0;
          state_d  = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // All state with synchronous active-high reset; reset aborts any op in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      msb_a_q  <= 1'b0;
      result_q <= '0;
      flag_z_q <= 1'b0;
      flag_v_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      msb_a_q  <= msb_a_d;
      result_q <= result_d;
      flag_z_q <= flag_z_d;
      flag_v_q <= flag_v_d;
      flag_n_q <= flag_n_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Handshake decoded from state; result and flags straight from registers
  always_comb begin
    busy   = (state_q == StRun) || (state_q == StDone);
    done   = (state_q == StDone);
    result = result_q;
    flag_z = flag_z_q;
    flag_v = flag_v_q;
    flag_n = flag_n_q;
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: one saturating and one wrapping instance
// share the stimulus; expected values are hand-computed constants.
module tb_serial_add_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;

  logic         s_busy, s_done, s_z, s_v, s_n;
  logic [W-1:0] s_result;
  logic         w_busy, w_done, w_z, w_v, w_n;
  logic [W-1:0] w_result;

  int passed = 0;
  int total  = 0;

  int first_done;
  int pulses;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W), .SAT(1'b1)) u_sat (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (s_busy),
    .done   (s_done),
    .result (s_result),
    .flag_z (s_z),
    .flag_v (s_v),
    .flag_n (s_n)
  );

  serial_add_ctrl #(.WIDTH(W), .SAT(1'b0)) u_wrap (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (w_busy),
    .done   (w_done),
    .result (w_result),
    .flag_z (w_z),
    .flag_v (w_v),
    .flag_n (w_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Result and flags of both instances as {result, Z, V, N}
  task automatic chk_out(input string tag, input logic [W-1:0] s_exp, input logic [2:0] s_f,
                         input logic [W-1:0] w_exp, input logic [2:0] w_f);
    chk({tag, " sat result"}, 32'(s_result), 32'(s_exp));
    chk({tag, " sat zvn"}, 32'({s_z, s_v, s_n}), 32'(s_f));
    chk({tag, " wrap result"}, 32'(w_result), 32'(w_exp));
    chk({tag, " wrap zvn"}, 32'({w_z, w_v, w_n}), 32'(w_f));
  endtask

  // Issue one op at E0 and watch done over E1..E_(W+1). Optionally re-assert start
  // mid-run and zero the operand inputs right after capture.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                        input int restart_at, input bit scramble,
                        output int fd, output int np);
    fd = -1;
    np = 0;
    @(negedge clk);
    a = av;
    b = bv;
    sub = sv;
    start = 1'b1;
    @(posedge clk);  // E0
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);  // between E_(k-1) and E_k
      if (k >= 2 && s_done) begin
        np++;
        if (fd < 0) fd = k - 1;
      end
      start = (k == restart_at);
      if (scramble) begin
        a = '0;
        b = '0;
        sub = 1'b0;
      end
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sub = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("reset busy", 32'(s_busy), 32'd0);
    chk("reset done", 32'(s_done), 32'd0);
    chk_out("reset", 16'h0000, 3'b000, 16'h0000, 3'b000);

    // 1: simple add, latency and single pulse
    run_op(16'h0003, 16'h0004, 1'b0, -1, 1'b0, first_done, pulses);
    chk("t1 done cycle", 32'(first_done), 32'(W));
    chk("t1 pulses", 32'(pulses), 32'd1);
    chk("t1 idle busy", 32'(s_busy), 32'd0);
    chk_out("t1", 16'h0007, 3'b000, 16'h0007, 3'b000);

    // 2: positive overflow
    run_op(16'h7FFF, 16'h0001, 1'b0, -1, 1'b0, first_done, pulses);
    chk_out("t2", 16'h7FFF, 3'b010, 16'h8000, 3'b011);

    // 3: negative overflow on subtract
    run_op(16'h8000, 16'h0001, 1'b1, -1, 1'b0, first_done, pulses);
    chk_out("t3", 16'h8000, 3'b011, 16'h7FFF, 3'b010);

    // 4: zero difference and borrow through all bits
    run_op(16'h1234, 16'h1234, 1'b1, -1, 1'b0, first_done, pulses);
    chk_out("t4a", 16'h0000, 3'b100, 16'h0000, 3'b100);
    run_op(16'h0000, 16'h0001, 1'b1, -1, 1'b0, first_done, pulses);
    chk_out("t4b", 16'hFFFF, 3'b001, 16'hFFFF, 3'b001);

    // Most-negative plus itself: wrap gives zero with V set
    run_op(16'h8000, 16'h8000, 1'b0, -1, 1'b0, first_done, pulses);
    chk_out("minmin", 16'h8000, 3'b011, 16'h0000, 3'b110);

    // 5: mid-run start ignored, inputs dropped after capture
    run_op(16'h0100, 16'h0023, 1'b0, 3, 1'b1, first_done, pulses);
    chk("t5 done cycle", 32'(first_done), 32'(W));
    chk("t5 pulses", 32'(pulses), 32'd1);
    chk_out("t5", 16'h0123, 3'b000, 16'h0123, 3'b000);
    a = 16'hFFFF;
    b = 16'hFFFF;
    sub = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5 held result", 32'(s_result), 32'h0123);

    // 6: reset sampled at E5 aborts a run
    a = 16'h0005;
    b = 16'h0006;
    sub = 1'b0;
    start = 1'b1;
    @(posedge clk);  // E0
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);  // before E4
    @(negedge clk);             // before E5
    rst = 1'b1;
    @(negedge clk);             // after E5
    chk("t6 busy", 32'(s_busy), 32'd0);
    chk("t6 done", 32'(s_done), 32'd0);
    chk_out("t6", 16'h0000, 3'b000, 16'h0000, 3'b000);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (s_done || w_done) pulses++;
    end
    chk("t6 no done", 32'(pulses), 32'd0);
    run_op(16'h0010, 16'h0020, 1'b1, -1, 1'b0, first_done, pulses);
    chk("t6 fresh done cycle", 32'(first_done), 32'(W));
    chk_out("t6 fresh", 16'hFFF0, 3'b001, 16'hFFF0, 3'b001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
